// File: rtl/sdram_burst_scheduler.sv
// Arbitrates the single SDRAM controller port between camera writes and display reads.
// Define SDRAM_SCHED_DOUBLE_BUFFER_EN to ping-pong write frames between two buffers.
`timescale 1ns/1ps
module sdram_burst_scheduler #(
    parameter int          VIDEO_END    = 153600,
    parameter int          BURST        = 8,
    parameter logic [21:0] FRAME_STRIDE = 22'h100000,
    parameter int          STARVE_LIMIT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rd_req,
    input  logic        wr_req,
    output logic        rd_grant,
    output logic        wr_grant,
    output logic        rd_beat,
    output logic        wr_beat,
    output logic [1:0]  ctrl_command,
    output logic [21:0] ctrl_data_address,
    input  logic        ctrl_data_read_valid,
    input  logic        ctrl_data_write_done,
    output logic        frame_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam int BEAT_W = $clog2(BURST + 1);
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(STARVE_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [21:0]       BURST_A   = 22'(BURST);
    localparam logic [21:0]       VEND_A    = 22'(VIDEO_END);

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [21:0]         rd_off_q, rd_off_d;
    logic [21:0]         wr_off_q, wr_off_d;
    logic [21:0]         rd_base_q, rd_base_d;
    logic [21:0]         wr_base_q, wr_base_d;
    logic [1:0]          cmd_q, cmd_d;
    logic [21:0]         addr_q, addr_d;
    logic                rd_grant_q, rd_grant_d;
    logic                wr_grant_q, wr_grant_d;
    logic                rd_beat_q, rd_beat_d;
    logic                frame_done_q, frame_done_d;

    logic [21:0]         rd_off_next, wr_off_next;
    logic                rd_wrap, wr_wrap;

`ifdef SDRAM_SCHED_DOUBLE_BUFFER_EN
    // Base of the most recently completed write frame; reads adopt it only at a frame boundary.
    logic [21:0]         done_base_q, done_base_d;
`else
    logic                unused_frame_stride;
    assign unused_frame_stride = ^FRAME_STRIDE;
`endif

    assign rd_off_next = rd_off_q + BURST_A;
    assign wr_off_next = wr_off_q + BURST_A;
    assign rd_wrap     = (rd_off_next == VEND_A);
    assign wr_wrap     = (wr_off_next == VEND_A);

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        wait_d       = wait_q;
        rd_off_d     = rd_off_q;
        wr_off_d     = wr_off_q;
        rd_base_d    = rd_base_q;
        wr_base_d    = wr_base_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        rd_grant_d   = 1'b0;
        wr_grant_d   = 1'b0;
        frame_done_d = 1'b0;
        rd_beat_d    = (state_q == READ) && ctrl_data_read_valid;
`ifdef SDRAM_SCHED_DOUBLE_BUFFER_EN
        done_base_d  = done_base_q;
`endif

        case (state_q)
            IDLE: begin
                // A write that has waited long enough pre-empts a pending read.
                if (wr_req && (wait_q >= WAIT_MAX)) begin
                    state_d    = WRITE;
                    wr_grant_d = 1'b1;
                    beat_d     = '0;
                    wait_d     = '0;
                    cmd_d      = CMD_WRITE;
                    addr_d     = wr_base_q + wr_off_q;
                end else if (rd_req) begin
                    state_d    = READ;
                    rd_grant_d = 1'b1;
                    beat_d     = '0;
                    cmd_d      = CMD_READ;
                    addr_d     = rd_base_q + rd_off_q;
                    if (wr_req && (wait_q < WAIT_MAX)) begin
                        wait_d = wait_q + WAIT_ONE;
                    end
                end else if (wr_req) begin
                    state_d    = WRITE;
                    wr_grant_d = 1'b1;
                    beat_d     = '0;
                    wait_d     = '0;
                    cmd_d      = CMD_WRITE;
                    addr_d     = wr_base_q + wr_off_q;
                end
            end

            READ: begin
                if (ctrl_data_read_valid) begin
                    beat_d = beat_q + BEAT_ONE;
                    if (beat_q == LAST_BEAT) begin
                        state_d  = IDLE;
                        cmd_d    = CMD_IDLE;
                        rd_off_d = rd_wrap ? '0 : rd_off_next;
`ifdef SDRAM_SCHED_DOUBLE_BUFFER_EN
                        if (rd_wrap) begin
                            rd_base_d = done_base_q;
                        end
`endif
                    end
                end
            end

            WRITE: begin
                if (ctrl_data_write_done) begin
                    beat_d = beat_q + BEAT_ONE;
                    if (beat_q == LAST_BEAT) begin
                        state_d      = IDLE;
                        cmd_d        = CMD_IDLE;
                        wr_off_d     = wr_wrap ? '0 : wr_off_next;
                        frame_done_d = wr_wrap;
`ifdef SDRAM_SCHED_DOUBLE_BUFFER_EN
                        if (wr_wrap) begin
                            done_base_d = wr_base_q;
                            wr_base_d   = (wr_base_q == '0) ? FRAME_STRIDE : '0;
                        end
`endif
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cmd_d   = CMD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            wait_q       <= '0;
            rd_off_q     <= '0;
            wr_off_q     <= '0;
            rd_base_q    <= '0;
            wr_base_q    <= '0;
            cmd_q        <= CMD_IDLE;
            addr_q       <= '0;
            rd_grant_q   <= 1'b0;
            wr_grant_q   <= 1'b0;
            rd_beat_q    <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef SDRAM_SCHED_DOUBLE_BUFFER_EN
            done_base_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            wait_q       <= wait_d;
            rd_off_q     <= rd_off_d;
            wr_off_q     <= wr_off_d;
            rd_base_q    <= rd_base_d;
            wr_base_q    <= wr_base_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            rd_grant_q   <= rd_grant_d;
            wr_grant_q   <= wr_grant_d;
            rd_beat_q    <= rd_beat_d;
            frame_done_q <= frame_done_d;
`ifdef SDRAM_SCHED_DOUBLE_BUFFER_EN
            done_base_q  <= done_base_d;
`endif
        end
    end

    // Write beats advance the camera FIFO in the same cycle the controller accepts them.
    assign wr_beat           = (state_q == WRITE) && ctrl_data_write_done;
    assign rd_beat           = rd_beat_q;
    assign rd_grant          = rd_grant_q;
    assign wr_grant          = wr_grant_q;
    assign ctrl_command      = cmd_q;
    assign ctrl_data_address = addr_q;
    assign frame_done        = frame_done_q;
    assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Directed bench for sdram_burst_scheduler: small frame (64 words) so address wrap is reachable.
// Handshake: a request level sampled in IDLE yields a one-cycle grant; beats are then counted until BURST.
`timescale 1ns/1ps
module tb_sdram_burst_scheduler;

    localparam int          VEND   = 64;
    localparam int          BURST  = 8;
    localparam int          LIMIT  = 4;
    localparam logic [21:0] STRIDE = 22'h100000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rd_req = 1'b0;
    logic        wr_req = 1'b0;
    logic        ctrl_data_read_valid = 1'b0;
    logic        ctrl_data_write_done = 1'b0;
    logic        rd_grant, wr_grant, rd_beat, wr_beat, frame_done, busy;
    logic [1:0]  ctrl_command;
    logic [21:0] ctrl_data_address;

    sdram_burst_scheduler #(
        .VIDEO_END    (VEND),
        .BURST        (BURST),
        .FRAME_STRIDE (STRIDE),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .rd_req               (rd_req),
        .wr_req               (wr_req),
        .rd_grant             (rd_grant),
        .wr_grant             (wr_grant),
        .rd_beat              (rd_beat),
        .wr_beat              (wr_beat),
        .ctrl_command         (ctrl_command),
        .ctrl_data_address    (ctrl_data_address),
        .ctrl_data_read_valid (ctrl_data_read_valid),
        .ctrl_data_write_done (ctrl_data_write_done),
        .frame_done           (frame_done),
        .busy                 (busy)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard and reference model
    int          n_cmp = 0;
    int          n_err = 0;
    int          rd_seen = 0;
    logic [21:0] exp_q[$];
    logic [21:0] m_rd_off, m_wr_off, m_rd_base, m_wr_base, m_done_base;
    int          m_wait;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rd_beat === 1'b1) rd_seen++;
    endtask

    task automatic model_reset();
        m_rd_off    = '0;
        m_wr_off    = '0;
        m_rd_base   = '0;
        m_wr_base   = '0;
        m_done_base = '0;
        m_wait      = 0;
        exp_q.delete();
    endtask

    function automatic logic [21:0] next_addr(input logic is_wr);
        return is_wr ? (m_wr_base + m_wr_off) : (m_rd_base + m_rd_off);
    endfunction

    task automatic model_complete(input logic is_wr);
        if (is_wr) begin
            if (m_wr_off + 22'(BURST) == 22'(VEND)) begin
                m_wr_off = '0;
`ifdef SDRAM_SCHED_DOUBLE_BUFFER_EN
                m_done_base = m_wr_base;
                m_wr_base   = (m_wr_base == '0) ? STRIDE : '0;
`endif
            end else begin
                m_wr_off = m_wr_off + 22'(BURST);
            end
        end else begin
            if (m_rd_off + 22'(BURST) == 22'(VEND)) begin
                m_rd_off = '0;
`ifdef SDRAM_SCHED_DOUBLE_BUFFER_EN
                m_rd_base = m_done_base;
`endif
            end else begin
                m_rd_off = m_rd_off + 22'(BURST);
            end
        end
    endtask

    // Driver: waits for a grant, pops the expected address, feeds n_beats controller beats
    task automatic serve_burst(input logic exp_wr, input int n_beats);
        logic        got;
        logic        exp_fd;
        logic [21:0] ea;
        logic [1:0]  exp_cmd;
        int          cnt;
        int          rd0;
        exp_cmd = exp_wr ? 2'd1 : 2'd2;
        got = 1'b0;
        for (int t = 0; t < 16; t++) begin
            tick();
            if (rd_grant === 1'b1 || wr_grant === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        ea = exp_q.pop_front();
        check("grant_seen", got, 1);
        if (!got) return;
        check("wr_grant", wr_grant, exp_wr);
        check("rd_grant", rd_grant, !exp_wr);
        check("cmd_start", ctrl_command, exp_cmd);
        check("addr_start", ctrl_data_address, ea);
        check("busy_start", busy, 1);
        check("frame_done_idle", frame_done, 0);
        if (exp_wr) m_wait = 0;
        else if (wr_req && m_wait < LIMIT) m_wait++;

        rd0 = rd_seen;
        cnt = 0;
        for (int i = 0; i < n_beats; i++) begin
            repeat ($urandom_range(0, 1)) tick();
            if (i == 2) begin
                // beat of the wrong type must be ignored
                if (exp_wr) ctrl_data_read_valid = 1'b1;
                else ctrl_data_write_done = 1'b1;
                #1;
                check("wr_beat_spurious", wr_beat, 0);
                tick();
                ctrl_data_read_valid = 1'b0;
                ctrl_data_write_done = 1'b0;
                check("rd_beat_spurious", rd_beat, 0);
                check("cmd_hold", ctrl_command, exp_cmd);
            end
            if (exp_wr) ctrl_data_write_done = 1'b1;
            else ctrl_data_read_valid = 1'b1;
            #1;
            if (exp_wr && wr_beat === 1'b1) cnt++;
            tick();
            ctrl_data_read_valid = 1'b0;
            ctrl_data_write_done = 1'b0;
        end
        if (n_beats < BURST) return;

        if (exp_wr) check("rd_beat_in_write", rd_seen - rd0, 0);
        else cnt = rd_seen - rd0;
        check("beat_count", cnt, BURST);
        check("cmd_end", ctrl_command, 0);
        check("busy_end", busy, 0);
        check("addr_hold", ctrl_data_address, ea);
        exp_fd = exp_wr && (m_wr_off + 22'(BURST) == 22'(VEND));
        check("frame_done", frame_done, exp_fd);
        model_complete(exp_wr);
    endtask

    task automatic burst(input logic is_wr);
        exp_q.push_back(next_addr(is_wr));
        serve_burst(is_wr, BURST);
    endtask

    // Directed sequence
    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd", ctrl_command, 0);
        check("rst_addr", ctrl_data_address, 0);
        check("rst_rd_grant", rd_grant, 0);
        check("rst_wr_grant", wr_grant, 0);
        check("rst_rd_beat", rd_beat, 0);
        check("rst_wr_beat", wr_beat, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;

        // two plain reads: addresses 0 and 8
        rd_req = 1'b1; burst(1'b0); rd_req = 1'b0;
        rd_req = 1'b1; burst(1'b0); rd_req = 1'b0;

        // spurious write beats while idle
        ctrl_data_write_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("idle_wr_beat", wr_beat, 0);
            tick();
            check("idle_busy", busy, 0);
            check("idle_cmd", ctrl_command, 0);
        end
        ctrl_data_write_done = 1'b0;

        // both requesters held: reads win until the write has waited LIMIT times
        rd_req = 1'b1;
        wr_req = 1'b1;
        for (int k = 0; k < 6; k++) burst(m_wait >= LIMIT);
        rd_req = 1'b0;
        wr_req = 1'b0;

        // finish the first write frame, then one write into the next frame
        wr_req = 1'b1;
        repeat (7) burst(1'b1);
        burst(1'b1);
        wr_req = 1'b0;

        // read frame wraps, next read starts at the completed buffer
        rd_req = 1'b1; burst(1'b0); burst(1'b0); rd_req = 1'b0;

        // second write frame completes
        wr_req = 1'b1;
        repeat (7) burst(1'b1);
        wr_req = 1'b0;

        // read frame wraps again, then a read from the newly completed buffer
        rd_req = 1'b1;
        repeat (8) burst(1'b0);
        rd_req = 1'b0;

        // reset in the middle of a write burst
        wr_req = 1'b1;
        exp_q.push_back(next_addr(1'b1));
        serve_burst(1'b1, 3);
        reset_n = 1'b0;
        ctrl_data_write_done = 1'b1;
        #1;
        check("async_rst_cmd", ctrl_command, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_wr_beat", wr_beat, 0);
        ctrl_data_write_done = 1'b0;
        wr_req = 1'b0;
        tick();
        tick();
        check("async_rst_addr", ctrl_data_address, 0);
        reset_n = 1'b1;
        model_reset();
        wr_req = 1'b1; burst(1'b1); wr_req = 1'b0;

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
